// File: rtl/serial_chunk_adder.sv
// Multi-cycle adder/subtractor: adds CHUNK bits per clock over WIDTH/CHUNK RUN cycles.
// Results, carry and signed overflow are registered on the edge that enters DONE.
module serial_chunk_adder #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    input  logic             carryIn,
    output logic [WIDTH-1:0] resultSum,
    output logic             resultCarry,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    localparam int unsigned N     = WIDTH / CHUNK;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               carry_q, carry_d;
    logic               res_carry_q, res_carry_d;
    logic               ovf_q, ovf_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [CHUNK-1:0]   chunk_sum_c;
    logic               chunk_cout_c;
    logic               msb_cin_c;
    logic               last_c;

    // Per-cycle chunk adder; carry into the chunk MSB recovered from the sum bit
    assign {chunk_cout_c, chunk_sum_c} = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]}
                                         + (CHUNK+1)'(carry_q);
    assign msb_cin_c = a_q[CHUNK-1] ^ b_q[CHUNK-1] ^ chunk_sum_c[CHUNK-1];
    assign last_c    = (cnt_q == CNT_W'(N - 1));

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        acc_d       = acc_q;
        sum_d       = sum_q;
        carry_d     = carry_q;
        res_carry_d = res_carry_q;
        ovf_d       = ovf_q;
        cnt_d       = cnt_q;
        busy_d      = 1'b0;
        done_d      = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = operandA;
                    b_d     = mode ? ~operandB : operandB;
                    carry_d = mode ? 1'b1 : carryIn;
                    cnt_d   = '0;
                    state_d = RUN;
                    busy_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                for (int unsigned i = 0; i < N; i++) begin
                    if (cnt_q == CNT_W'(i)) begin
                        acc_d[i*CHUNK +: CHUNK] = chunk_sum_c;
                    end
                end
                carry_d = chunk_cout_c;
                a_d     = a_q >> CHUNK;
                b_d     = b_q >> CHUNK;
                cnt_d   = cnt_q + CNT_W'(1);
                busy_d  = 1'b1;
                if (last_c) begin
                    // Publish only the completed word, never partial chunks
                    state_d     = DONE;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    sum_d       = acc_d;
                    res_carry_d = chunk_cout_c;
                    ovf_d       = msb_cin_c ^ chunk_cout_c;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            res_carry_q <= 1'b0;
            ovf_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            res_carry_q <= res_carry_d;
            ovf_q       <= ovf_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cnt_q       <= cnt_d;
        end
    end

    assign resultSum   = sum_q;
    assign resultCarry = res_carry_q;
    assign overflow    = ovf_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_serial_chunk_adder.sv
// Bench for serial_chunk_adder: vector table plus corner sequences, results
// checked through a queue popped on each done pulse.
module tb_serial_chunk_adder;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned CHUNK = 4;
    localparam int unsigned N     = WIDTH / CHUNK;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             carry;
        logic             ovf;
    } res_t;

    typedef struct {
        logic             mode;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
        res_t             exp;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             mode;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             carry_in;
    logic [WIDTH-1:0] result_sum;
    logic             result_carry;
    logic             overflow;
    logic             busy;
    logic             done;

    int   errors = 0;
    int   checks = 0;
    res_t exp_q[$];
    res_t last_res;
    vec_t vecs[8];

    serial_chunk_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .mode        (mode),
        .operandA    (op_a),
        .operandB    (op_b),
        .carryIn     (carry_in),
        .resultSum   (result_sum),
        .resultCarry (result_carry),
        .overflow    (overflow),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic res_t model(input logic m, input logic [WIDTH-1:0] a,
                                   input logic [WIDTH-1:0] b, input logic cin);
        res_t             r;
        logic [WIDTH-1:0] bb;
        logic [WIDTH:0]   t;
        bb      = m ? ~b : b;
        t       = {1'b0, a} + {1'b0, bb} + (WIDTH+1)'(m ? 1'b1 : cin);
        r.sum   = t[WIDTH-1:0];
        r.carry = t[WIDTH];
        r.ovf   = (a[WIDTH-1] == bb[WIDTH-1]) && (r.sum[WIDTH-1] != a[WIDTH-1]);
        return r;
    endfunction

    // Scoreboard: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        res_t e;
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_done: got done=1 expected no pulse at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                check("sum",   32'(result_sum),   32'(e.sum));
                check("carry", 32'(result_carry), 32'(e.carry));
                check("ovf",   32'(overflow),     32'(e.ovf));
            end
        end
    end

    // Called at a negedge; returns at the negedge where done should be high.
    task automatic run_op(input logic m, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic cin, input res_t e, input int inject);
        int busy_cnt = 0;
        int hold_bad = 0;
        exp_q.push_back(e);
        mode     = m;
        op_a     = a;
        op_b     = b;
        carry_in = cin;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i <= int'(N); i++) begin
            if (i == inject) begin
                start = 1'b1;
                op_a  = 16'hAAAA;
                mode  = ~m;
            end else begin
                start = 1'b0;
            end
            if (busy === 1'b1 && done === 1'b0) busy_cnt++;
            if (result_sum !== last_res.sum || result_carry !== last_res.carry ||
                overflow !== last_res.ovf) hold_bad++;
            @(negedge clk);
        end
        start = 1'b0;
        check("busy_cycles", 32'(busy_cnt), 32'(N));
        check("done_pulse",  32'({busy, done}), 32'h1);
        check("hold_prev",   32'(hold_bad), 32'h0);
        last_res = e;
    endtask

    initial begin
        res_t             e;
        logic [WIDTH-1:0] ra, rb;
        logic             rm, rc;

        vecs[0] = '{1'b0, 16'h1234, 16'h4321, 1'b0, '{16'h5555, 1'b0, 1'b0}};
        vecs[1] = '{1'b0, 16'hFFFF, 16'h0001, 1'b0, '{16'h0000, 1'b1, 1'b0}};
        vecs[2] = '{1'b0, 16'h7FFF, 16'h0001, 1'b0, '{16'h8000, 1'b0, 1'b1}};
        vecs[3] = '{1'b0, 16'h0001, 16'h0001, 1'b1, '{16'h0003, 1'b0, 1'b0}};
        vecs[4] = '{1'b1, 16'h0005, 16'h0007, 1'b0, '{16'hFFFE, 1'b0, 1'b0}};
        vecs[5] = '{1'b1, 16'h8000, 16'h0001, 1'b0, '{16'h7FFF, 1'b1, 1'b1}};
        vecs[6] = '{1'b1, 16'h0003, 16'h0003, 1'b1, '{16'h0000, 1'b1, 1'b0}};
        vecs[7] = '{1'b0, 16'h8000, 16'h8000, 1'b0, '{16'h0000, 1'b1, 1'b1}};

        rst      = 1'b1;
        start    = 1'b0;
        mode     = 1'b0;
        op_a     = '0;
        op_b     = '0;
        carry_in = 1'b0;
        last_res = '0;
        repeat (2) @(negedge clk);
        check("rst_sum",   32'(result_sum),   32'h0);
        check("rst_carry", 32'(result_carry), 32'h0);
        check("rst_ovf",   32'(overflow),     32'h0);
        check("rst_busy",  32'(busy),         32'h0);
        check("rst_done",  32'(done),         32'h0);

        // First start right after reset release; consecutive calls start in DONE
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].mode, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].exp, 0);
            if (i % 3 == 2) repeat (2) @(negedge clk);
        end

        for (int i = 0; i < 6; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rm = 1'($urandom);
            rc = 1'($urandom);
            run_op(rm, ra, rb, rc, model(rm, ra, rb, rc), 0);
        end
        repeat (2) @(negedge clk);

        // start pulsed mid-RUN with different operands must be ignored
        run_op(1'b0, 16'h1234, 16'h4321, 1'b0, '{16'h5555, 1'b0, 1'b0}, 2);
        repeat (8) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'h0);

        // Reset just before edge t+3 aborts the operation
        mode     = 1'b0;
        op_a     = 16'h1111;
        op_b     = 16'h2222;
        carry_in = 1'b0;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_busy",  32'(busy),         32'h0);
        check("abort_done",  32'(done),         32'h0);
        check("abort_sum",   32'(result_sum),   32'h0);
        check("abort_carry", 32'(result_carry), 32'h0);
        check("abort_ovf",   32'(overflow),     32'h0);
        repeat (3) @(negedge clk);
        rst      = 1'b0;
        last_res = '0;
        run_op(1'b0, 16'h00FF, 16'h0F01, 1'b0, model(1'b0, 16'h00FF, 16'h0F01, 1'b0), 0);
        run_op(1'b1, 16'h0000, 16'h0001, 1'b0, '{16'hFFFF, 1'b0, 1'b0}, 0);
        repeat (8) @(negedge clk);
        check("final_idle_busy", 32'(busy), 32'h0);
        check("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
